// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the two-road traffic light controller.
//   - state_t       : FSM state codes; the code is also exported as state_dbg
//   - LIGHT_*       : one-hot light head encodings {red, yellow, green}
//   - lights_t      : main/side light head pair
//   - decode_lights : maps a state code onto both light heads
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED1    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED2    = 3'd5
    } state_t;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    typedef struct packed {
        logic [2:0] main_light;
        logic [2:0] side_light;
    } lights_t;

    // Unused codes 6/7 show red on both heads; they only last one cycle
    // because the FSM forces them back to MAIN_GREEN.
    function automatic lights_t decode_lights(input state_t s);
        lights_t l;
        l.main_light = LIGHT_RED;
        l.side_light = LIGHT_RED;
        case (s)
            MAIN_GREEN:  l.main_light = LIGHT_GRN;
            MAIN_YELLOW: l.main_light = LIGHT_YEL;
            SIDE_GREEN:  l.side_light = LIGHT_GRN;
            SIDE_YELLOW: l.side_light = LIGHT_YEL;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl_if
//   Bundles the road-side signals of the traffic light controller.
//   Requests : car_sensor (level), ped_req (pulse or level)
//   Outputs  : main_light, side_light (one-hot {R,Y,G}), walk, ped_pending,
//              state_dbg (current FSM state code)
//   master : the road side (sensors/buttons drive, lamps observe)
//   slave  : the controller
// -----------------------------------------------------------------------------
interface traffic_light_ctrl_if;

    logic       car_sensor;
    logic       ped_req;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       ped_pending;
    logic [2:0] state_dbg;

    modport master (
        output car_sensor,
        output ped_req,
        input  main_light,
        input  side_light,
        input  walk,
        input  ped_pending,
        input  state_dbg
    );

    modport slave (
        input  car_sensor,
        input  ped_req,
        output main_light,
        output side_light,
        output walk,
        output ped_pending,
        output state_dbg
    );

endinterface

// File: rtl/dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
//   Two independent down-counters timing the long (green) and short
//   (yellow / all-red) dwells.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears both counters
//   trL   : one-cycle trigger, (re)starts the long count
//   trS   : one-cycle trigger, (re)starts the short count
//   tL    : one-cycle pulse LONG_CYCLES-1 cycles after the trL cycle
//   tS    : one-cycle pulse SHORT_CYCLES-1 cycles after the trS cycle
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int LONG_CYCLES  = 8,
    parameter int SHORT_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic trL,
    input  logic trS,
    output logic tL,
    output logic tS
);

    // A count of N-1 fits in clog2(N) bits for any N >= 2.
    localparam int LW = $clog2(LONG_CYCLES);
    localparam int SW = $clog2(SHORT_CYCLES);

    localparam logic [LW-1:0] LONG_LOAD  = LW'(LONG_CYCLES - 1);
    localparam logic [SW-1:0] SHORT_LOAD = SW'(SHORT_CYCLES - 1);
    localparam logic [LW-1:0] LONG_ONE   = LW'(1);
    localparam logic [SW-1:0] SHORT_ONE  = SW'(1);

    logic [LW-1:0] long_cnt;
    logic [SW-1:0] short_cnt;

    // The trigger cycle loads N-1; k cycles later the count reads N-k, so
    // the count equals 1 exactly N-1 cycles after the trigger. Zero is idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            long_cnt <= '0;
        end else if (trL) begin
            long_cnt <= LONG_LOAD;
        end else if (long_cnt != '0) begin
            long_cnt <= long_cnt - LONG_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            short_cnt <= '0;
        end else if (trS) begin
            short_cnt <= SHORT_LOAD;
        end else if (short_cnt != '0) begin
            short_cnt <= short_cnt - SHORT_ONE;
        end
    end

    assign tL = (long_cnt == LONG_ONE);
    assign tS = (short_cnt == SHORT_ONE);

endmodule

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//   Two-road intersection controller. The main road rests on green; the side
//   road gets a fixed green phase when a car is sensed or a pedestrian request
//   is latched once the main green has dwelt its minimum time.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of traffic_light_ctrl_if
//           car_sensor, ped_req in; main_light, side_light, walk,
//           ped_pending, state_dbg out (all Moore, from registers)
// -----------------------------------------------------------------------------
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int LONG_CYCLES  = 8,
    parameter int SHORT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    traffic_light_ctrl_if.slave  bus
);

    state_t  state;
    state_t  next_state;
    logic    entry;         // first cycle in the current state
    logic    long_done;     // minimum main-green dwell already elapsed
    logic    ped_latch;
    logic    walk_grant;
    logic    trL;
    logic    trS;
    logic    tL;
    logic    tS;
    logic    entering_side;
    logic    leaving_main;
    lights_t lights;

    dwell_timer #(
        .LONG_CYCLES  (LONG_CYCLES),
        .SHORT_CYCLES (SHORT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .trL   (trL),
        .trS   (trS),
        .tL    (tL),
        .tS    (tS)
    );

    // Next state and timer triggers. The triggers fire in the first cycle of
    // each timed state so every state lasts exactly its dwell.
    always_comb begin
        next_state = state;
        trL        = 1'b0;
        trS        = 1'b0;
        case (state)
            MAIN_GREEN: begin
                trL = entry;
                // car_sensor is a live level; only ped requests are latched
                if ((tL || long_done) && (bus.car_sensor || ped_latch)) begin
                    next_state = MAIN_YELLOW;
                end
            end
            MAIN_YELLOW: begin
                trS = entry;
                if (tS) next_state = ALL_RED1;
            end
            ALL_RED1: begin
                trS = entry;
                if (tS) next_state = SIDE_GREEN;
            end
            SIDE_GREEN: begin
                trL = entry;
                if (tL) next_state = SIDE_YELLOW;
            end
            SIDE_YELLOW: begin
                trS = entry;
                if (tS) next_state = ALL_RED2;
            end
            ALL_RED2: begin
                trS = entry;
                if (tS) next_state = MAIN_GREEN;
            end
            default: next_state = MAIN_GREEN;
        endcase
    end

    assign entering_side = (next_state == SIDE_GREEN) && (state != SIDE_GREEN);
    assign leaving_main  = (state == MAIN_GREEN) && (next_state != MAIN_GREEN);

    // Reset leaves entry set, so the first cycle after release behaves as a
    // fresh MAIN_GREEN entry and starts the long timer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= MAIN_GREEN;
            entry      <= 1'b1;
            long_done  <= 1'b0;
            ped_latch  <= 1'b0;
            walk_grant <= 1'b0;
        end else begin
            state <= next_state;
            entry <= (next_state != state);

            if (leaving_main) begin
                long_done <= 1'b0;
            end else if ((state == MAIN_GREEN) && tL) begin
                long_done <= 1'b1;
            end

            // The request pending at the edge into SIDE_GREEN (including one
            // arriving at that very edge) becomes this phase's walk grant and
            // is not re-latched. Later requests wait for the next phase.
            if (entering_side) begin
                walk_grant <= ped_latch || bus.ped_req;
                ped_latch  <= 1'b0;
            end else if (bus.ped_req) begin
                ped_latch  <= 1'b1;
            end
        end
    end

    assign lights          = decode_lights(state);
    assign bus.main_light  = lights.main_light;
    assign bus.side_light  = lights.side_light;
    assign bus.walk        = (state == SIDE_GREEN) && walk_grant;
    assign bus.ped_pending = ped_latch;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//   Directed bench for traffic_light_ctrl with default parameters
//   (LONG_CYCLES=8, SHORT_CYCLES=3). Cycle 0 is the first cycle after reset
//   release; inputs set in cycle k are sampled at the edge ending cycle k.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

    localparam logic [2:0] S_MG  = 3'd0;
    localparam logic [2:0] S_MY  = 3'd1;
    localparam logic [2:0] S_AR1 = 3'd2;
    localparam logic [2:0] S_SG  = 3'd3;
    localparam logic [2:0] S_SY  = 3'd4;
    localparam logic [2:0] S_AR2 = 3'd5;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    traffic_light_ctrl_if tl_if ();

    traffic_light_ctrl #(
        .LONG_CYCLES  (8),
        .SHORT_CYCLES (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tl_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_main(input logic [2:0] st);
        case (st)
            S_MG:    return 3'b001;
            S_MY:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input logic [2:0] st);
        case (st)
            S_SG:    return 3'b001;
            S_SY:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic check_cycle(input string tag, input logic [2:0] st,
                               input logic w, input logic p);
        check({tag, ".state"}, 8'(tl_if.state_dbg),   8'(st));
        check({tag, ".main"},  8'(tl_if.main_light),  8'(exp_main(st)));
        check({tag, ".side"},  8'(tl_if.side_light),  8'(exp_side(st)));
        check({tag, ".walk"},  8'(tl_if.walk),        8'(w));
        check({tag, ".pend"},  8'(tl_if.ped_pending), 8'(p));
    endtask

    // Check n consecutive cycles of one state, leaving the bench at the
    // first cycle after them.
    task automatic expect_phase(input string tag, input logic [2:0] st, input int n,
                                input logic w, input logic p);
        for (int i = 0; i < n; i++) begin
            check_cycle(tag, st, w, p);
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    initial begin
        clk                = 1'b0;
        reset              = 1'b0;
        vectors            = 0;
        miscompares        = 0;
        tl_if.car_sensor   = 1'b0;
        tl_if.ped_req      = 1'b0;

        // 1: idle after reset, trigger only on the release cycle
        step();
        check_cycle("t1.rst", S_MG, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check_cycle("t1.idle", S_MG, 1'b0, 1'b0);
            check("t1.trL", 8'(dut.trL), (i == 0) ? 8'd1 : 8'd0);
            step();
        end

        // 2: car present from release, one full cycle
        tl_if.car_sensor = 1'b1;
        do_reset();
        expect_phase("t2.mg",  S_MG,  8, 1'b0, 1'b0);
        expect_phase("t2.my",  S_MY,  3, 1'b0, 1'b0);
        expect_phase("t2.ar1", S_AR1, 3, 1'b0, 1'b0);
        expect_phase("t2.sg",  S_SG,  8, 1'b0, 1'b0);
        expect_phase("t2.sy",  S_SY,  3, 1'b0, 1'b0);
        expect_phase("t2.ar2", S_AR2, 3, 1'b0, 1'b0);
        check_cycle("t2.back", S_MG, 1'b0, 1'b0);

        // 3: late one-cycle car pulse after long_done is set
        tl_if.car_sensor = 1'b0;
        do_reset();
        expect_phase("t3.wait", S_MG, 20, 1'b0, 1'b0);
        tl_if.car_sensor = 1'b1;
        expect_phase("t3.car", S_MG, 1, 1'b0, 1'b0);
        tl_if.car_sensor = 1'b0;
        expect_phase("t3.my",  S_MY,  3, 1'b0, 1'b0);
        expect_phase("t3.ar1", S_AR1, 3, 1'b0, 1'b0);
        expect_phase("t3.sg",  S_SG,  8, 1'b0, 1'b0);
        expect_phase("t3.sy",  S_SY,  3, 1'b0, 1'b0);
        expect_phase("t3.ar2", S_AR2, 3, 1'b0, 1'b0);
        expect_phase("t3.hold", S_MG, 12, 1'b0, 1'b0);

        // 4: pedestrian pulse in cycle 2 earns a walk phase
        do_reset();
        expect_phase("t4.mg0", S_MG, 2, 1'b0, 1'b0);
        tl_if.ped_req = 1'b1;
        expect_phase("t4.req", S_MG, 1, 1'b0, 1'b0);
        tl_if.ped_req = 1'b0;
        expect_phase("t4.mg1", S_MG,  5, 1'b0, 1'b1);
        expect_phase("t4.my",  S_MY,  3, 1'b0, 1'b1);
        expect_phase("t4.ar1", S_AR1, 3, 1'b0, 1'b1);
        expect_phase("t4.sg",  S_SG,  8, 1'b1, 1'b0);
        expect_phase("t4.sy",  S_SY,  3, 1'b0, 1'b0);
        expect_phase("t4.ar2", S_AR2, 3, 1'b0, 1'b0);
        expect_phase("t4.hold", S_MG, 10, 1'b0, 1'b0);

        // 5: reset pulse in SIDE_GREEN with a latched request
        tl_if.car_sensor = 1'b1;
        do_reset();
        expect_phase("t5.mg",  S_MG,  8, 1'b0, 1'b0);
        expect_phase("t5.my",  S_MY,  3, 1'b0, 1'b0);
        expect_phase("t5.ar1", S_AR1, 3, 1'b0, 1'b0);
        tl_if.car_sensor = 1'b0;
        expect_phase("t5.sg0", S_SG, 1, 1'b0, 1'b0);
        tl_if.ped_req = 1'b1;
        expect_phase("t5.sg1", S_SG, 1, 1'b0, 1'b0);
        tl_if.ped_req = 1'b0;
        expect_phase("t5.sg2", S_SG, 1, 1'b0, 1'b1);
        reset = 1'b0;
        expect_phase("t5.sg3", S_SG, 1, 1'b0, 1'b1);
        reset = 1'b1;
        expect_phase("t5.hold", S_MG, 20, 1'b0, 1'b0);

        // 6: request during SIDE_GREEN is served in the following phase
        tl_if.car_sensor = 1'b1;
        do_reset();
        expect_phase("t6.mg",  S_MG, 8, 1'b0, 1'b0);
        tl_if.car_sensor = 1'b0;
        expect_phase("t6.my",  S_MY,  3, 1'b0, 1'b0);
        expect_phase("t6.ar1", S_AR1, 3, 1'b0, 1'b0);
        expect_phase("t6.sg0", S_SG,  3, 1'b0, 1'b0);
        tl_if.ped_req = 1'b1;
        expect_phase("t6.sgq", S_SG,  1, 1'b0, 1'b0);
        tl_if.ped_req = 1'b0;
        expect_phase("t6.sg1", S_SG,  4, 1'b0, 1'b1);
        expect_phase("t6.sy",  S_SY,  3, 1'b0, 1'b1);
        expect_phase("t6.ar2", S_AR2, 3, 1'b0, 1'b1);
        expect_phase("t6.mg2", S_MG,  8, 1'b0, 1'b1);
        expect_phase("t6.my2", S_MY,  3, 1'b0, 1'b1);
        expect_phase("t6.ar3", S_AR1, 3, 1'b0, 1'b1);
        expect_phase("t6.sg2", S_SG,  8, 1'b1, 1'b0);
        expect_phase("t6.sy2", S_SY,  3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
